// File: rtl/raw_frame_ddr_writer_if.sv
// Avalon-MM burst write bus between raw_frame_ddr_writer (master) and the DDR controller port (slave).
interface raw_frame_ddr_writer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [63:0]       avm_writedata;
    logic [7:0]        avm_byteenable;
    logic [6:0]        avm_burstcount;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        output avm_burstcount,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        input  avm_burstcount,
        output avm_waitrequest
    );
endinterface

// File: rtl/raw_frame_ddr_writer.sv
// Buffers the packed RAW stream in a show-ahead FIFO and writes frames to DDR in fixed bursts; RAW_WR_PINGPONG_EN enables buffer ping-pong.
// state | meaning: IDLE wait for start_frame | ARMED fill FIFO | BURST issue one burst | DRAIN flush after abort
module raw_frame_ddr_writer #(
    parameter int                ADDR_W      = 32,
    parameter int                BURST_LEN   = 16,
    parameter int                FIFO_DEPTH  = 64,
    parameter int                FRAME_WORDS = 115200,
    parameter logic [ADDR_W-1:0] BASE_ADDR_0 = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] BASE_ADDR_1 = 32'h0010_0000
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   start_frame,
    input  logic [63:0]            data_ddr,
    input  logic                   valid_data_ddr,
    raw_frame_ddr_writer_if.master avm,
    output logic                   frame_done,
    output logic                   frame_abort,
    output logic                   frame_buf_sel,
    output logic                   overflow
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int CNT_W  = $clog2(FRAME_WORDS + 1);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LVL_BURST = LVL_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0]  CNT_BURST = CNT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN * 8);

    if (FRAME_WORDS % BURST_LEN != 0) begin : g_frame_words_chk
        $error("raw_frame_ddr_writer: FRAME_WORDS must be a multiple of BURST_LEN");
    end

    typedef enum logic [1:0] {IDLE, ARMED, BURST, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [63:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_nxt;
    logic [LVL_W-1:0]   level;
    logic [CNT_W-1:0]   accepted, written;
    logic [BEAT_W-1:0]  beat;
    logic               wr_buf, next_buf, abort_pending;
    logic               setup, flush, done, abort, take, push, pop, ovf_set, last_beat;

    // Reset value of the buffer select makes the first frame land in buffer 0.
`ifdef RAW_WR_PINGPONG_EN
    localparam logic SEL_RST = 1'b1;
    assign next_buf = ~wr_buf;
`else
    localparam logic SEL_RST = 1'b0;
    assign next_buf = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        setup     = 1'b0;
        flush     = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        pop       = avm.avm_write && !avm.avm_waitrequest;
        last_beat = pop && (beat == BEAT_LAST);
        rd_nxt    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        // Words seen with or after an abort request belong to no frame.
        take      = valid_data_ddr && (accepted != CNT_FRAME) && !start_frame &&
                    ((state == ARMED) || (state == BURST && !abort_pending));
        push      = take && (level != LVL_FULL);
        ovf_set   = take && (level == LVL_FULL);
        case (state)
            IDLE: begin
                if (start_frame) begin
                    setup     = 1'b1;
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (start_frame) begin
                    setup = 1'b1;
                    flush = 1'b1;
                    abort = 1'b1;
                end else if (level >= LVL_BURST) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (last_beat) begin
                    if (abort_pending || start_frame) begin
                        state_nxt = DRAIN;
                    end else if (written + CNT_BURST == CNT_FRAME) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = ARMED;
                    end
                end
            end
            DRAIN: begin
                setup     = 1'b1;
                flush     = 1'b1;
                abort     = 1'b1;
                state_nxt = ARMED;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= data_ddr;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state              <= IDLE;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            level              <= '0;
            accepted           <= '0;
            written            <= '0;
            beat               <= '0;
            wr_buf             <= SEL_RST;
            abort_pending      <= 1'b0;
            avm.avm_address    <= '0;
            avm.avm_write      <= 1'b0;
            avm.avm_writedata  <= '0;
            avm.avm_byteenable <= '0;
            avm.avm_burstcount <= '0;
            frame_done         <= 1'b0;
            frame_abort        <= 1'b0;
            frame_buf_sel      <= SEL_RST;
            overflow           <= 1'b0;
        end else begin
            state              <= state_nxt;
            frame_done         <= done;
            frame_abort        <= abort;
            avm.avm_write      <= (state_nxt == BURST);
            avm.avm_byteenable <= (state_nxt == BURST) ? 8'hFF : 8'h00;
            avm.avm_burstcount <= (state_nxt == BURST) ? 7'(BURST_LEN) : 7'd0;

            if (start_frame)  overflow <= 1'b0;
            else if (ovf_set) overflow <= 1'b1;

            if (state == BURST && start_frame) abort_pending <= 1'b1;
            if (done) frame_buf_sel <= wr_buf;

            if (setup) begin
                abort_pending   <= 1'b0;
                wr_buf          <= next_buf;
                avm.avm_address <= next_buf ? BASE_ADDR_1 : BASE_ADDR_0;
                accepted        <= '0;
                written         <= '0;
                beat            <= '0;
            end else begin
                if (push) accepted <= accepted + CNT_W'(1);
                if (pop)  beat     <= beat + BEAT_W'(1);
                if (last_beat) begin
                    avm.avm_address <= avm.avm_address + ADDR_STEP;
                    written         <= written + CNT_BURST;
                end
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                rd_ptr <= rd_nxt;
                case ({push, pop})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
            end

            // Show-ahead head: a word pushed into an empty (or emptying) FIFO becomes the head directly.
            if (push && (wr_ptr == rd_nxt)) avm.avm_writedata <= data_ddr;
            else if (pop)                   avm.avm_writedata <= mem[rd_nxt];
        end
    end
endmodule
